// File: rtl/dma_io_endpoint.sv
// Peripheral-side 8237-style DMA endpoint with local FIFO; DMA_EP_DEMAND_EN enables demand mode.
// Latency: bus pins are registered once, so each pin event acts on the FSM one clock later.
// Backpressure: DREQ is held off until the FIFO has THRESH bytes or slots; local ports use valid/ready.

module dma_ep_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   push_i,
    input  logic [W-1:0]           push_dat_i,
    input  logic                   pop_i,
    output logic [W-1:0]           head_dat_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push_ok, pop_ok;

    assign push_ok    = push_i && (count_q != FULL);
    assign pop_ok     = pop_i && (count_q != '0);
    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

module dma_io_endpoint #(
    parameter int DEPTH  = 8,
    parameter int THRESH = 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   dir_i,
    input  logic                   enable_i,
    output logic                   dreq_o,
    input  logic                   dack_i,
    input  logic                   ior_n_i,
    input  logic                   iow_n_i,
    input  logic                   eop_n_i,
    input  logic [7:0]             db_in_i,
    output logic [7:0]             db_out_o,
    output logic                   db_oe_o,
    input  logic                   loc_in_valid_i,
    output logic                   loc_in_ready_o,
    input  logic [7:0]             loc_in_data_i,
    output logic                   loc_out_valid_o,
    input  logic                   loc_out_ready_i,
    output logic [7:0]             loc_out_data_o,
    output logic                   tc_o,
    input  logic                   tc_clr_i,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_REQ  = 5'b00010,
        S_ACK  = 5'b00100,
        S_XFER = 5'b01000,
        S_DONE = 5'b10000
    } state_e;

    state_e      state_q, state_d;
    logic        dir_q, live_q, eop_seen_q;
    logic        dack_q, ior_n_q, iow_n_q, eop_n_q;
    logic [7:0]  hold_q, head;
    logic        need, strobe_act, eop_now, in_grant;
    logic        bus_pop, bus_push, fifo_push, fifo_pop;
    logic [7:0]  fifo_dat;

    assign need = dir_q ? ((DEPTH - int'(count_o)) >= THRESH) : (int'(count_o) >= THRESH);
`ifdef DMA_EP_DEMAND_EN
    logic need_post;
    // Need condition as it will stand once the current byte has moved.
    assign need_post = dir_q ? ((DEPTH - int'(count_o)) > THRESH) : (int'(count_o) > THRESH);
`endif
    assign strobe_act = dir_q ? ~iow_n_q : ~ior_n_q;
    assign in_grant   = (state_q == S_ACK) || (state_q == S_XFER);
    assign eop_now    = eop_seen_q || ~eop_n_q;

    always_comb begin
        state_d  = state_q;
        bus_pop  = 1'b0;
        bus_push = 1'b0;
        case (state_q)
            S_IDLE: if (enable_i && need) state_d = S_REQ;
            S_REQ: begin
                if (dack_q)         state_d = S_ACK;
                else if (!enable_i) state_d = S_IDLE;
            end
            S_ACK: begin
                if (!dack_q)         state_d = S_IDLE;
                else if (strobe_act) state_d = S_XFER;
            end
            S_XFER: begin
                if (!strobe_act || !dack_q) begin
                    bus_pop  = ~dir_q;
                    bus_push = dir_q;
                    if (eop_now) state_d = S_DONE;
`ifdef DMA_EP_DEMAND_EN
                    else if (dack_q && need_post) state_d = S_ACK;
`endif
                    else state_d = S_IDLE;
                end
            end
            S_DONE: if (tc_clr_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            dir_q      <= 1'b0;
            live_q     <= 1'b0;
            eop_seen_q <= 1'b0;
            dack_q     <= 1'b0;
            ior_n_q    <= 1'b1;
            iow_n_q    <= 1'b1;
            eop_n_q    <= 1'b1;
            hold_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            live_q     <= 1'b1;
            dack_q     <= dack_i;
            ior_n_q    <= ior_n_i;
            iow_n_q    <= iow_n_i;
            eop_n_q    <= eop_n_i;
            eop_seen_q <= in_grant && eop_now;
            if (state_q == S_IDLE) dir_q <= dir_i;
            // Track the bus while the write strobe is low so a 1-CLK strobe still lands a byte.
            if (in_grant && dir_q && !iow_n_i) hold_q <= db_in_i;
        end
    end

    assign fifo_push = dir_q ? bus_push : (loc_in_valid_i && loc_in_ready_o);
    assign fifo_pop  = dir_q ? (loc_out_valid_o && loc_out_ready_i) : bus_pop;
    assign fifo_dat  = dir_q ? hold_q : loc_in_data_i;

    dma_ep_fifo #(.W(8), .DEPTH(DEPTH)) u_fifo (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .push_i     (fifo_push),
        .push_dat_i (fifo_dat),
        .pop_i      (fifo_pop),
        .head_dat_o (head),
        .count_o    (count_o)
    );

    assign dreq_o          = (state_q == S_REQ) || (state_q == S_ACK);
    assign tc_o            = (state_q == S_DONE);
    assign db_oe_o         = (state_q == S_XFER) && !dir_q;
    assign db_out_o        = (db_oe_o && count_o != '0) ? head : 8'h00;
    assign loc_in_ready_o  = live_q && !dir_q && (count_o != FULL);
    assign loc_out_valid_o = live_q && dir_q && (count_o != '0);
    assign loc_out_data_o  = loc_out_valid_o ? head : 8'h00;
endmodule

// File: tb/tb_dma_io_endpoint.sv
// Bench for dma_io_endpoint: vector table of single transfers, hand sequences, and randomized traffic
// checked against a byte-queue model of the FIFO contents.
module tb_dma_io_endpoint;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef DMA_EP_DEMAND_EN
    localparam bit DEMAND = 1'b1;
`else
    localparam bit DEMAND = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, dir, en, dreq, dack, ior_n, iow_n, eop_n, db_oe;
    logic          liv, lir, lov, lor, tc, tc_clr;
    logic [7:0]    db_in, db_out, lid, lod;
    logic [CW-1:0] count;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    dma_io_endpoint #(.DEPTH(DEPTH), .THRESH(1)) dut (
        .clk_i(clk), .reset_i(rst), .dir_i(dir), .enable_i(en), .dreq_o(dreq),
        .dack_i(dack), .ior_n_i(ior_n), .iow_n_i(iow_n), .eop_n_i(eop_n),
        .db_in_i(db_in), .db_out_o(db_out), .db_oe_o(db_oe),
        .loc_in_valid_i(liv), .loc_in_ready_o(lir), .loc_in_data_i(lid),
        .loc_out_valid_o(lov), .loc_out_ready_i(lor), .loc_out_data_o(lod),
        .tc_o(tc), .tc_clr_i(tc_clr), .count_o(count)
    );

    typedef struct {
        bit         d;
        logic [7:0] dat;
        int         width;
        bit         eop;
        bit         abort;
        bit         exp_oe;
        logic [7:0] exp_db;
        int         exp_cnt;
        bit         exp_tc;
        bit         exp_dreq;
        logic [7:0] exp_lod;
    } vec_t;

    vec_t       vt[8];
    logic [7:0] q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input bit d);
        rst = 1'b1; dir = d; en = 1'b0; dack = 1'b0; ior_n = 1'b1; iow_n = 1'b1;
        eop_n = 1'b1; db_in = 8'h00; liv = 1'b0; lid = 8'h00; lor = 1'b0; tc_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        en = 1'b1;
    endtask

    task automatic local_push(input logic [7:0] d);
        int n = 0;
        liv = 1'b1; lid = d;
        while (!lir && n < 20) begin tick(); n++; end
        chk("push_ready", lir, 1'b1);
        tick();
        liv = 1'b0;
    endtask

    task automatic local_pop(output logic [7:0] d);
        int n = 0;
        while (!lov && n < 20) begin tick(); n++; end
        chk("pop_valid", lov, 1'b1);
        d = lod;
        lor = 1'b1;
        tick();
        lor = 1'b0;
    endtask

    task automatic bus_xfer(input bit d, input logic [7:0] wdat, input int width,
                            input bit eop, input bit abort,
                            output logic [7:0] rdat, output logic oe);
        int n = 0;
        rdat = 8'h00; oe = 1'b0;
        while (!dreq && n < 40) begin tick(); n++; end
        chk("dreq_before_grant", dreq, 1'b1);
        dack = 1'b1;
        tick(); tick();
        if (abort) begin
            dack = 1'b0;
        end else begin
            if (d) begin db_in = wdat; iow_n = 1'b0; end
            else ior_n = 1'b0;
            eop_n = ~eop;
            repeat (width) tick();
            ior_n = 1'b1; iow_n = 1'b1; eop_n = 1'b1; liv = 1'b0;
            tick();
            oe = db_oe; rdat = db_out;
            tick();
            dack = 1'b0;
        end
        repeat (4) tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] rd, exp_b;
        logic       oe;
        int         n, nread;

        vt[0] = '{0, 8'hA5, 3, 0, 0, 1, 8'hA5, 0, 0, 0, 8'h00};
        vt[1] = '{0, 8'h5A, 1, 0, 0, 1, 8'h5A, 0, 0, 0, 8'h00};
        vt[2] = '{0, 8'hC3, 2, 1, 0, 1, 8'hC3, 0, 1, 0, 8'h00};
        vt[3] = '{0, 8'h77, 2, 0, 1, 0, 8'h00, 1, 0, 1, 8'h00};
        vt[4] = '{1, 8'h3C, 3, 0, 0, 0, 8'h00, 1, 0, 1, 8'h3C};
        vt[5] = '{1, 8'h81, 1, 0, 0, 0, 8'h00, 1, 0, 1, 8'h81};
        vt[6] = '{1, 8'hF0, 2, 1, 0, 0, 8'h00, 1, 1, 0, 8'hF0};
        vt[7] = '{1, 8'h99, 2, 0, 1, 0, 8'h00, 0, 0, 1, 8'h00};

        // Reset values, sampled while reset is held.
        rst = 1'b1; dir = 1'b0; en = 1'b1; dack = 1'b0; ior_n = 1'b1; iow_n = 1'b1;
        eop_n = 1'b1; db_in = 8'hFF; liv = 1'b1; lid = 8'h12; lor = 1'b1; tc_clr = 1'b0;
        tick(); tick();
        chk("rst_dreq", dreq, 1'b0);
        chk("rst_db_out", db_out, 8'h00);
        chk("rst_db_oe", db_oe, 1'b0);
        chk("rst_tc", tc, 1'b0);
        chk("rst_count", count, 0);
        chk("rst_loc_in_ready", lir, 1'b0);
        chk("rst_loc_out_valid", lov, 1'b0);
        chk("rst_loc_out_data", lod, 8'h00);

        // Single-transfer vectors, each from a fresh reset.
        for (int i = 0; i < 8; i++) begin
            do_reset(vt[i].d);
            if (!vt[i].d) local_push(vt[i].dat);
            bus_xfer(vt[i].d, vt[i].dat, vt[i].width, vt[i].eop, vt[i].abort, rd, oe);
            chk($sformatf("vec%0d_oe", i), oe, vt[i].exp_oe);
            chk($sformatf("vec%0d_db", i), rd, vt[i].exp_db);
            chk($sformatf("vec%0d_count", i), count, vt[i].exp_cnt);
            chk($sformatf("vec%0d_tc", i), tc, vt[i].exp_tc);
            chk($sformatf("vec%0d_dreq", i), dreq, vt[i].exp_dreq);
            chk($sformatf("vec%0d_lod", i), lod, vt[i].exp_lod);
        end

        // Terminal count holds off DREQ until TC_CLR.
        do_reset(1'b0);
        local_push(8'h11);
        local_push(8'h22);
        bus_xfer(1'b0, 8'h00, 2, 1'b1, 1'b0, rd, oe);
        chk("tc_first_byte", rd, 8'h11);
        chk("tc_set", tc, 1'b1);
        repeat (3) tick();
        chk("tc_dreq_held", dreq, 1'b0);
        chk("tc_count", count, 1);
        tc_clr = 1'b1; tick(); tc_clr = 1'b0;
        chk("tc_cleared", tc, 1'b0);
        n = 0;
        while (!dreq && n < 10) begin tick(); n++; end
        chk("tc_dreq_again", dreq, 1'b1);
        bus_xfer(1'b0, 8'h00, 2, 1'b0, 1'b0, rd, oe);
        chk("tc_second_byte", rd, 8'h22);

        // Full FIFO with a blocked local push during a bus pop, then random traffic with wrap.
        do_reset(1'b0);
        q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            exp_b = 8'($urandom);
            local_push(exp_b);
            q.push_back(exp_b);
        end
        chk("full_count", count, DEPTH);
        liv = 1'b1; lid = 8'hEE;
        tick();
        chk("full_ready_low", lir, 1'b0);
        bus_xfer(1'b0, 8'h00, 2, 1'b0, 1'b0, rd, oe);
        chk("full_pop_data", rd, q.pop_front());
        chk("full_count_after", count, q.size());
        nread = 1;
        for (int it = 0; it < 200 && nread < 20; it++) begin
            if (q.size() < DEPTH && (q.size() == 0 || $urandom_range(1, 0) == 1)) begin
                exp_b = 8'($urandom);
                local_push(exp_b);
                q.push_back(exp_b);
            end else begin
                bus_xfer(1'b0, 8'h00, $urandom_range(3, 1), 1'b0, 1'b0, rd, oe);
                chk("rd_oe", oe, 1'b1);
                chk("rd_data", rd, q.pop_front());
                nread++;
            end
            chk("rd_count", count, q.size());
        end

        // Memory-to-device random traffic.
        do_reset(1'b1);
        q.delete();
        for (int it = 0; it < 24; it++) begin
            if (q.size() < DEPTH && (q.size() == 0 || $urandom_range(2, 0) != 0)) begin
                exp_b = 8'($urandom);
                bus_xfer(1'b1, exp_b, $urandom_range(3, 1), 1'b0, 1'b0, rd, oe);
                q.push_back(exp_b);
            end else begin
                local_pop(rd);
                chk("wr_data", rd, q.pop_front());
            end
            chk("wr_count", count, q.size());
        end

        // Reset during XFER discards the byte.
        do_reset(1'b0);
        local_push(8'h4E);
        n = 0;
        while (!dreq && n < 20) begin tick(); n++; end
        dack = 1'b1; tick(); tick();
        ior_n = 1'b0; tick(); tick(); tick();
        chk("midx_oe", db_oe, 1'b1);
        chk("midx_db", db_out, 8'h4E);
        rst = 1'b1; tick();
        chk("midx_rst_oe", db_oe, 1'b0);
        chk("midx_rst_count", count, 0);
        chk("midx_rst_dreq", dreq, 1'b0);
        rst = 1'b0; ior_n = 1'b1; dack = 1'b0;
        tick(); tick();
        chk("midx_after_count", count, 0);

        // Four bytes under one held DACK: DREQ stays up only in demand mode.
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) local_push(8'hD1 + 8'(i));
        n = 0;
        while (!dreq && n < 20) begin tick(); n++; end
        dack = 1'b1; tick(); tick();
        for (int p = 0; p < 4; p++) begin
            n = 0;
            while (!dreq && n < 20) begin tick(); n++; end
            ior_n = 1'b0;
            repeat (3) tick();
            ior_n = 1'b1;
            tick();
            chk($sformatf("dm_oe%0d", p), db_oe, 1'b1);
            chk($sformatf("dm_data%0d", p), db_out, 8'hD1 + 8'(p));
            tick();
            if (p < 3) chk($sformatf("dm_dreq%0d", p), dreq, DEMAND);
        end
        dack = 1'b0;
        repeat (4) tick();
        chk("dm_count", count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dma_io_endpoint.md
# dma_io_endpoint

Peripheral-side DMA endpoint: the device end of the 8237A-style DREQ/DACK/IOR_N/IOW_N/EOP_N channel driven by the DMA timing controller. It raises DREQ when its local FIFO can source or sink a byte. It then completes one byte transfer per active IOR_N or IOW_N strobe while DACK is high, and latches terminal count on EOP_N. It sits between the DMA channel pins and a local valid/ready stream inside the peripheral.

## Interface
Parameters:
- DEPTH, 8 — FIFO entries; power of two, 2..64.
- THRESH, 1 — minimum occupancy (device→memory) or free slots (memory→device) before DREQ is raised; 1..DEPTH.

Ports:
- CLK  in  1  system clock; one clock domain.
- RESET  in  1  synchronous, active-high reset.
- DIR  in  1  0 = device→memory (DMA write transfer, IOR_N strobes); 1 = memory→device (DMA read transfer, IOW_N strobes); sampled only in IDLE.
- ENABLE  in  1  allows new requests.
- DREQ  out  1  DMA request to the controller.
- DACK  in  1  DMA acknowledge, active high.
- IOR_N  in  1  I/O read strobe, active low.
- IOW_N  in  1  I/O write strobe, active low.
- EOP_N  in  1  end of process / terminal count, active low.
- DB_IN  in  8  data bus input.
- DB_OUT  out  8  data bus output, FIFO head.
- DB_OE  out  1  data bus output enable.
- LOC_IN_VALID / LOC_IN_READY / LOC_IN_DATA[7:0]  in/out/in  local producer into FIFO; used when DIR=0.
- LOC_OUT_VALID / LOC_OUT_READY / LOC_OUT_DATA[7:0]  out/in/out  local consumer from FIFO; used when DIR=1.
- TC  out  1  terminal count latched.
- TC_CLR  in  1  clears TC and returns the FSM to IDLE.
- COUNT  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- FSM states: IDLE, REQ, ACK, XFER, DONE. This is a one-hot Moore machine.
- IDLE: DREQ=0; latches DIR into dir_q.
  - Go to REQ when ENABLE=1 and TC=0 and the need condition holds.
  - Need condition: COUNT≥THRESH if dir_q=0; DEPTH−COUNT≥THRESH if dir_q=1.
- REQ: DREQ=1.
  - DACK=1 → ACK.
  - ENABLE=0 → IDLE.
- ACK: DREQ=1.
  - DACK=1 with the active strobe low (IOR_N if dir_q=0, IOW_N if dir_q=1) → XFER.
  - DACK=0 → IDLE with no FIFO change (aborted grant).
  - The inactive strobe is ignored.
- XFER: DREQ=0.
  - dir_q=0: DB_OE=1 and DB_OUT=FIFO head.
  - dir_q=1: DB_IN is captured into a holding register every cycle.
  - When the strobe returns high or DACK falls: dir_q=0 pops the head; dir_q=1 pushes the holding register. Exactly one byte either way.
  - Next state: DONE if EOP_N was sampled low at any cycle in ACK or XFER, else IDLE.
- DONE: TC=1, DREQ=0. Stays until TC_CLR=1, then → IDLE and TC=0.
- Local side: LOC_IN_READY = (dir_q=0 && COUNT<DEPTH); LOC_OUT_VALID = (dir_q=1 && COUNT>0).
  - A local operation in the same cycle as the bus pop or push is legal; COUNT nets to the correct value.
  - FIFO pointers wrap modulo DEPTH; COUNT never exceeds DEPTH or goes below 0.
- Error case: a bus pop with an empty FIFO (dir_q=0) drives 8'h00 and is not counted. Likewise a push with a full FIFO is dropped. Neither case occurs while THRESH≥1 is respected.

## Timing
- Reset values: DREQ=0, DB_OUT=8'h00, DB_OE=0, TC=0, COUNT=0, LOC_IN_READY=0, LOC_OUT_VALID=0, LOC_OUT_DATA=8'h00. FSM=IDLE, FIFO emptied, dir_q=0.
- RESET wins over every other input in the same cycle. Reset mid-XFER discards the in-flight byte.
- All outputs are registered or decoded from registered state. Nothing is combinational from the bus pins.
- Latencies:
  - Need condition true at edge n → DREQ=1 after edge n+1.
  - DACK high at edge n → ACK after n+1.
  - Strobe low at edge m → DB_OE=1 after m+1.
  - Strobe high at edge k → FIFO update and DB_OE=0 after k+1.
- Minimum strobe-low width is 1 CLK. The 8237 S2–S4 window of ≥2 CLK is covered.
- EOP_N and TC_CLR asserted together in XFER: EOP wins and the FSM enters DONE. TC_CLR is honoured only in DONE.

## Configuration
- DMA_EP_DEMAND_EN defined: demand mode.
  - On strobe release in XFER, if DACK=1, EOP not seen and the need condition still holds, the FSM returns to ACK with DREQ=1 instead of going to IDLE.
  - This allows back-to-back bytes under a single grant.
- Undefined: single mode. Every byte goes XFER→IDLE and needs a fresh DREQ/DACK handshake.

## Test plan
- DIR=0, THRESH=1: push 8'hA5 locally → DREQ=1 two cycles later; DACK=1 then IOR_N low 3 CLK → DB_OE=1, DB_OUT=8'hA5. IOR_N high → COUNT 1→0, DREQ=0, IDLE.
- DIR=1: DREQ=1 on an empty FIFO. DACK, IOW_N low with DB_IN=8'h3C then high → COUNT=1, LOC_OUT_VALID=1, LOC_OUT_DATA=8'h3C.
- EOP_N low during XFER → TC=1, DREQ stays 0 with FIFO data present. TC_CLR pulse → IDLE, then DREQ re-asserts.
- DACK drops in ACK without a strobe → IDLE, COUNT unchanged, DREQ re-asserts.
- DEPTH=8, DIR=0: fill to 8, simultaneous local push attempt and bus pop → LOC_IN_READY=0 while full, COUNT=7 afterwards. Pointer wrap verified over 20 bytes in order.
- With DMA_EP_DEMAND_EN, 4 bytes queued, DACK held: four IOR_N pulses → DREQ never drops between them, bytes in order. Without the macro, DREQ drops after each byte.
